// File: rtl/host_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : host_link_ctrl
// Description : Host end of the three-bus valid/ready accelerator link. Starts
//               the chip, streams 48-bit words onto con_1..3 and buffers the
//               tagged results the chip returns. Optional macro
//               HOST_LINK_STATS_EN enables the tx_count/rx_count counters.
// Revision    : 1.0 - initial release
// ============================================================================
module host_link_ctrl #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int TURNAROUND         = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_in,
    input  logic                                    start_in,
    output logic                                    busy,
    output logic                                    done,
    input  logic                                    src_valid,
    output logic                                    src_ready,
    input  logic [3*IO_DATA_WIDTH-1:0]              src_data,
    inout  wire  [IO_DATA_WIDTH-1:0]                con_1,
    inout  wire  [IO_DATA_WIDTH-1:0]                con_2,
    inout  wire  [IO_DATA_WIDTH-1:0]                con_3,
    output logic                                    con_valid,
    input  logic                                    con_ready,
    output logic                                    chip_start,
    input  logic                                    chip_running,
    input  logic                                    driving_cons,
    input  logic                                    output_valid,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
    output logic                                    sink_valid,
    input  logic                                    sink_ready,
    output logic [3*IO_DATA_WIDTH-1:0]              sink_data,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    sink_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   sink_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   sink_ch,
    output logic                                    overflow,
    output logic [31:0]                             tx_count,
    output logic [31:0]                             rx_count
);

    localparam int c_W   = IO_DATA_WIDTH;
    localparam int c_XW  = $clog2(FEATURE_MAP_WIDTH);
    localparam int c_YW  = $clog2(FEATURE_MAP_HEIGHT);
    localparam int c_CW  = $clog2(OUTPUT_NB_CHANNELS);
    localparam int c_EW  = 3*c_W + c_XW + c_YW + c_CW;
    localparam int c_TAW = $clog2(TURNAROUND + 1);
    localparam logic [c_TAW-1:0] c_TA = c_TAW'(TURNAROUND);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_RUN = 3'd2,
        S_STREAM   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_TAW-1:0]   r_ta_cnt;
    logic               r_tx_full;
    logic [3*c_W-1:0]   r_tx_data;
    logic [c_EW-1:0]    r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_cnt;

    logic w_stream, w_start_entry, w_drive_ok, w_tx_xfer, w_src_take;
    logic w_cap, w_pop, w_full, w_push, w_drop;

    assign w_stream      = (r_state == S_STREAM);
    assign w_start_entry = (r_state == S_IDLE) && start_in;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            chip_start <= 1'b0;
        end else begin
            chip_start <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                S_IDLE: if (start_in) begin
                    r_state    <= S_START;
                    chip_start <= 1'b1;
                    busy       <= 1'b1;
                end
                S_START:    r_state <= S_WAIT_RUN;
                S_WAIT_RUN: if (chip_running) r_state <= S_STREAM;
                S_STREAM: if (!chip_running) begin
                    r_state <= S_DONE;
                    done    <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Counter holds off the host for TURNAROUND idle cycles after the chip lets go.
    always_ff @(posedge clk) begin
        if (rst_in || driving_cons)
            r_ta_cnt <= c_TA;
        else if (r_ta_cnt != '0)
            r_ta_cnt <= r_ta_cnt - c_TAW'(1);
    end

    // driving_cons and rst_in act combinationally so the bus is freed in the same cycle.
    assign w_drive_ok = w_stream && !driving_cons && (r_ta_cnt == '0) && !rst_in;
    assign con_valid  = w_drive_ok && r_tx_full;
    assign w_tx_xfer  = con_valid && con_ready;
    assign src_ready  = w_stream && (!r_tx_full || w_tx_xfer);
    assign w_src_take = src_valid && src_ready;

    always_ff @(posedge clk) begin
        if (rst_in || !w_stream)
            r_tx_full <= 1'b0;
        else if (w_src_take)
            r_tx_full <= 1'b1;
        else if (w_tx_xfer)
            r_tx_full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_src_take)
            r_tx_data <= src_data;
    end

    assign con_1 = w_drive_ok ? r_tx_data[c_W-1:0]       : {c_W{1'bz}};
    assign con_2 = w_drive_ok ? r_tx_data[2*c_W-1:c_W]   : {c_W{1'bz}};
    assign con_3 = w_drive_ok ? r_tx_data[3*c_W-1:2*c_W] : {c_W{1'bz}};

    // Two-entry result FIFO; a pop frees space for a same-cycle push.
    assign sink_valid = (r_cnt != 2'd0);
    assign w_full     = (r_cnt == 2'd2);
    assign w_pop      = sink_valid && sink_ready;
    assign w_cap      = w_stream && output_valid && driving_cons;
    assign w_push     = w_cap && (!w_full || w_pop);
    assign w_drop     = w_cap && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_start_entry)
                overflow <= 1'b0;
            else if (w_drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {con_3, con_2, con_1, output_x, output_y, output_ch};
    end

    assign {sink_data, sink_x, sink_y, sink_ch} = r_mem[r_rptr];

`ifdef HOST_LINK_STATS_EN
    logic [31:0] r_tx_count;
    logic [31:0] r_rx_count;

    always_ff @(posedge clk) begin
        if (rst_in || w_start_entry) begin
            r_tx_count <= 32'd0;
            r_rx_count <= 32'd0;
        end else begin
            if (w_tx_xfer) r_tx_count <= r_tx_count + 32'd1;
            if (w_push)    r_rx_count <= r_rx_count + 32'd1;
        end
    end

    assign tx_count = r_tx_count;
    assign rx_count = r_rx_count;
`else
    assign tx_count = 32'd0;
    assign rx_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_host_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_link_ctrl
// Description : Scoreboard bench for host_link_ctrl: directed link scenarios
//               followed by a randomized run against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_link_ctrl;
    localparam int W  = 16;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int CW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_in, start_in, con_ready, chip_running, driving_cons, output_valid, sink_ready;
    logic src_valid = 1'b0;
    logic [3*W-1:0] src_data = '0;
    logic [XW-1:0] output_x;
    logic [YW-1:0] output_y;
    logic [CW-1:0] output_ch;
    wire  [W-1:0] con_1, con_2, con_3;
    logic busy, done, src_ready, con_valid, chip_start, sink_valid, overflow;
    logic [3*W-1:0] sink_data;
    logic [XW-1:0] sink_x;
    logic [YW-1:0] sink_y;
    logic [CW-1:0] sink_ch;
    logic [31:0] tx_count, rx_count;

    // Chip-side bus drivers
    logic chip_drv_en;
    logic [3*W-1:0] chip_bus;
    assign con_1 = chip_drv_en ? chip_bus[W-1:0]     : {W{1'bz}};
    assign con_2 = chip_drv_en ? chip_bus[2*W-1:W]   : {W{1'bz}};
    assign con_3 = chip_drv_en ? chip_bus[3*W-1:2*W] : {W{1'bz}};

    host_link_ctrl dut (
        .clk(clk), .rst_in(rst_in), .start_in(start_in), .busy(busy), .done(done),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .con_1(con_1), .con_2(con_2), .con_3(con_3),
        .con_valid(con_valid), .con_ready(con_ready), .chip_start(chip_start),
        .chip_running(chip_running), .driving_cons(driving_cons), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_data(sink_data),
        .sink_x(sink_x), .sink_y(sink_y), .sink_ch(sink_ch),
        .overflow(overflow), .tx_count(tx_count), .rx_count(rx_count)
    );

    typedef struct packed {
        logic [3*W-1:0] d;
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
        logic [CW-1:0]  c;
    } res_t;

    logic [3*W-1:0] src_q[$];
    logic [3*W-1:0] tx_exp[$];
    res_t           sink_exp[$];
    int             xfer_cyc[$];
    bit             src_take = 1'b0;
    bit             mon_en = 1'b0;
    bit             overflow_exp = 1'b0;
    int             run_tx = 0;
    int             run_rx = 0;
    int             cyc_n = 0;
    int             src_gap_pct = 0;
    int             checks = 0;
    int             errors = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor / scoreboard: model FIFO occupancy, compare every handshake
    always @(negedge clk) begin
        res_t r;
        bit   mpop;
        cyc_n++;
        src_take = 1'b0;
        if (mon_en) begin
            chk("sink_valid", sink_valid, sink_exp.size() != 0);
            if (driving_cons || rst_in) chk("con_valid_released", con_valid, 0);
            if (!rst_in) begin
                if (con_valid && con_ready) begin
                    xfer_cyc.push_back(cyc_n);
                    if (tx_exp.size() == 0) chk("tx_unexpected", 1, 0);
                    else chk("tx_data", {con_3, con_2, con_1}, tx_exp.pop_front());
                end
                if (src_valid && src_ready) begin
                    tx_exp.push_back(src_data);
                    src_take = 1'b1;
                    run_tx++;
                end
                mpop = sink_ready && (sink_exp.size() != 0);
                if (mpop) begin
                    r = sink_exp.pop_front();
                    chk("sink_data", sink_data, r.d);
                    chk("sink_tags", {sink_x, sink_y, sink_ch}, {r.x, r.y, r.c});
                end
                if (output_valid && driving_cons) begin
                    if (sink_exp.size() < 2) begin
                        r.d = chip_bus; r.x = output_x; r.y = output_y; r.c = output_ch;
                        sink_exp.push_back(r);
                        run_rx++;
                    end else begin
                        overflow_exp = 1'b1;
                    end
                end
            end else begin
                tx_exp.delete();
                sink_exp.delete();
                overflow_exp = 1'b0;
            end
        end
    end

    // Source driver: presents src_q head, advancing when the monitor saw an accept
    always @(posedge clk) begin
        #1;
        if (src_take && src_q.size() != 0) void'(src_q.pop_front());
        if (src_q.size() != 0 && $urandom_range(99) >= src_gap_pct) begin
            src_valid = 1'b1;
            src_data  = src_q[0];
        end else begin
            src_valid = 1'b0;
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        cyc(); start_in = 1'b1; overflow_exp = 1'b0; run_tx = 0; run_rx = 0;
        cyc(); start_in = 1'b0;
        @(negedge clk);
        chk("chip_start_pulse", chip_start, 1);
        chk("busy_in_start", busy, 1);
        cyc(); chip_running = 1'b1;
        @(negedge clk);
        chk("chip_start_single", chip_start, 0);
        cyc();
    endtask

    task automatic wait_tx_drain(string nm, int budget);
        int n = 0;
        while ((src_q.size() != 0 || tx_exp.size() != 0 || src_valid) && n < budget) begin
            cyc(); n++;
        end
        chk(nm, (src_q.size() == 0 && tx_exp.size() == 0), 1);
    endtask

    task automatic wait_sink_drain(string nm, int budget);
        int n = 0;
        while (sink_exp.size() != 0 && n < budget) begin
            cyc(); n++;
        end
        chk(nm, sink_exp.size(), 0);
    endtask

    task automatic end_run();
        chip_running = 1'b0;
        cyc(); @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        cyc(); @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [15:0] vals [3];
        logic [63:0] rw;
        logic [63:0] rb;
        int          dc;
        vals = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        rst_in = 1'b1; start_in = 1'b0; con_ready = 1'b0; chip_running = 1'b0;
        driving_cons = 1'b0; output_valid = 1'b0; output_x = '0; output_y = '0; output_ch = '0;
        sink_ready = 1'b0; chip_drv_en = 1'b0; chip_bus = '0;
        cyc(3); rst_in = 1'b0; mon_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_chip_start", chip_start, 0); chk("rst_con_valid", con_valid, 0);
        chk("rst_src_ready", src_ready, 0);   chk("rst_overflow", overflow, 0);
        chk("rst_tx_count", tx_count, 0);     chk("rst_rx_count", rx_count, 0);

        // Run 1: basic stream
        start_run();
        con_ready = 1'b1; xfer_cyc.delete();
        for (int i = 0; i < 4; i++)
            src_q.push_back({16'(3*i+1), 16'(3*i+2), 16'(3*i+3)});
        for (int n = 0; n < 20 && xfer_cyc.size() < 4; n++) cyc();
        chk("basic_xfers", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) chk("basic_back_to_back", xfer_cyc[3] - xfer_cyc[0], 3);
        cyc(2); @(negedge clk);
`ifdef HOST_LINK_STATS_EN
        chk("basic_tx_count", tx_count, 4);
`else
        chk("basic_tx_count", tx_count, 0);
`endif

        // Backpressure
        con_ready = 1'b0;
        src_q.push_back(48'h1111_2222_3333);
        src_q.push_back(48'h4444_5555_6666);
        cyc(4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_con_valid", con_valid, 1);
            chk("bp_lanes", {con_3, con_2, con_1}, 48'h1111_2222_3333);
            chk("bp_src_ready", src_ready, 0);
            cyc();
        end
        con_ready = 1'b1;
        @(negedge clk);
        chk("bp_reload_ready", src_ready, 1);
        wait_tx_drain("bp_drain", 20);

        // Bus handover
        con_ready = 1'b0;
        src_q.push_back(48'h7777_8888_9999);
        cyc(4);
        driving_cons = 1'b1; chip_drv_en = 1'b1; chip_bus = '0; con_ready = 1'b1;
        @(negedge clk);
        chk("ho_valid_drop", con_valid, 0);
        chk("ho_bus_released", {con_3, con_2, con_1}, 0);
        cyc(); driving_cons = 1'b0; chip_drv_en = 1'b0;
        @(negedge clk);
        chk("ho_turnaround", con_valid, 0);
        cyc(); @(negedge clk);
        chk("ho_redrive", con_valid, 1);
        wait_tx_drain("ho_drain", 10);

        // Capture, ignore and overflow
        sink_ready = 1'b0;
        cyc(); output_valid = 1'b1; output_x = 10'd1;
        cyc(); output_valid = 1'b0;
        @(negedge clk);
        chk("ignore_unowned", sink_valid, 0);
        for (int k = 0; k < 3; k++) begin
            driving_cons = 1'b1; chip_drv_en = 1'b1; chip_bus = {3{vals[k]}};
            output_valid = 1'b1; output_x = 10'd5; output_y = 10'd7; output_ch = 6'd3;
            cyc();
        end
        output_valid = 1'b0; driving_cons = 1'b0; chip_drv_en = 1'b0;
        @(negedge clk);
        chk("ovf_set", overflow, 1);
        chk("ovf_buffered", sink_valid, 1);
        cyc(); @(negedge clk);
`ifdef HOST_LINK_STATS_EN
        chk("ovf_rx_count", rx_count, 2);
`else
        chk("ovf_rx_count", rx_count, 0);
`endif
        sink_ready = 1'b1;
        wait_sink_drain("ovf_drain", 10);
        end_run();

        // Run 2: randomized traffic
        start_run();
        chk("rnd_ovf_cleared", overflow, 0);
        src_gap_pct = 25; dc = 0;
        for (int t = 0; t < 300; t++) begin
            rw = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            con_ready  = ($urandom_range(3) != 0);
            sink_ready = 1'($urandom_range(1));
            if (src_q.size() < 2) src_q.push_back(rw[3*W-1:0]);
            if (dc == 0 && $urandom_range(9) == 0) dc = $urandom_range(4, 1);
            if (dc > 0) begin
                driving_cons = 1'b1; chip_drv_en = 1'b1; chip_bus = rb[3*W-1:0];
                output_valid = 1'($urandom_range(1));
                output_x = XW'($urandom); output_y = YW'($urandom); output_ch = CW'($urandom);
                dc--;
            end else begin
                driving_cons = 1'b0; chip_drv_en = 1'b0;
                output_valid = ($urandom_range(9) == 0);
            end
            cyc();
        end
        driving_cons = 1'b0; chip_drv_en = 1'b0; output_valid = 1'b0; con_ready = 1'b1;
        wait_tx_drain("rnd_tx_drain", 60);
        cyc(2); @(negedge clk);
`ifdef HOST_LINK_STATS_EN
        chk("rnd_tx_count", tx_count, 32'(run_tx));
        chk("rnd_rx_count", rx_count, 32'(run_rx));
`else
        chk("rnd_tx_count", tx_count, 0);
        chk("rnd_rx_count", rx_count, 0);
`endif
        chk("rnd_overflow", overflow, overflow_exp);
        src_gap_pct = 0;
        end_run();
        sink_ready = 1'b1;
        wait_sink_drain("idle_sink_drain", 20);

        // Run 3: reset in the middle of streaming
        start_run();
        sink_ready = 1'b0; con_ready = 1'b0;
        src_q.push_back(48'hDEAD_BEEF_CAFE);
        driving_cons = 1'b1; chip_drv_en = 1'b1; chip_bus = 48'h0000_0000_0001;
        output_valid = 1'b1; output_x = 10'd2; output_y = 10'd4; output_ch = 6'd6;
        cyc();
        output_valid = 1'b0; driving_cons = 1'b0; chip_drv_en = 1'b0;
        cyc(4); @(negedge clk);
        chk("rst_pre_offer", con_valid, 1);
        cyc(); rst_in = 1'b1; chip_drv_en = 1'b1; chip_bus = '0;
        @(negedge clk);
        chk("rst_bus_release_comb", {con_3, con_2, con_1}, 0);
        cyc(); rst_in = 1'b0; src_q.delete(); chip_running = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_bus", {con_3, con_2, con_1}, 0);
        chk("midrst_src_ready", src_ready, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_tx_count", tx_count, 0);
        chk("midrst_rx_count", rx_count, 0);
        cyc(); chip_drv_en = 1'b0;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
